// File: rtl/hit_resolver_if.sv
// Bundle between the two character FSMs and the combat referee.
// The master side drives the frame strobe plus both players' state and x position.
// The slave side (hit_resolver) returns:
//   - stun requests with block flag and frame count,
//   - health values,
//   - round state and winner.
interface hit_resolver_if;
  logic       frame_en;
  logic [3:0] p1_state;
  logic [9:0] p1_pos_x;
  logic [3:0] p2_state;
  logic [9:0] p2_pos_x;
  logic       p1_stun_req;
  logic       p1_stun_blk;
  logic [4:0] p1_stun_frm;
  logic       p2_stun_req;
  logic       p2_stun_blk;
  logic [4:0] p2_stun_frm;
  logic [7:0] p1_health;
  logic [7:0] p2_health;
  logic [1:0] round_state;
  logic [1:0] winner;

  modport master (
    output frame_en, p1_state, p1_pos_x, p2_state, p2_pos_x,
    input  p1_stun_req, p1_stun_blk, p1_stun_frm,
    input  p2_stun_req, p2_stun_blk, p2_stun_frm,
    input  p1_health, p2_health, round_state, winner
  );

  modport slave (
    input  frame_en, p1_state, p1_pos_x, p2_state, p2_pos_x,
    output p1_stun_req, p1_stun_blk, p1_stun_frm,
    output p2_stun_req, p2_stun_blk, p2_stun_frm,
    output p1_health, p2_health, round_state, winner
  );
endinterface

// File: rtl/hit_resolver.sv
// Combat referee. On each frame_en strobe it checks each attacker's active hitbox against
// the opponent's hurtbox, then decides hit or block. It applies damage, pulses one-cycle
// stun requests, and runs the FIGHT -> KO -> OVER round sequence.
// Ports:
//   clk - clock
//   rst - asynchronous, active-high reset
//   bus - hit_resolver_if.slave:
//         inputs:  frame strobe, player states and positions
//         outputs: stun requests, health, round state and winner
module hit_resolver #(
  parameter logic [7:0] HpMax     = 8'd100,
  parameter logic [7:0] BasicDmg  = 8'd10,
  parameter logic [7:0] DirDmg    = 8'd15,
  parameter logic [4:0] BasicHitF = 5'd19,
  parameter logic [4:0] BasicBlkF = 5'd15,
  parameter logic [4:0] DirHitF   = 5'd20,
  parameter logic [4:0] DirBlkF   = 5'd16,
  parameter logic [5:0] KoHold    = 6'd60
) (
  input logic          clk,
  input logic          rst,
  hit_resolver_if.slave bus
);

  localparam logic [3:0] StateBwd   = 4'd2;
  localparam logic [3:0] StateBasic = 4'd4;
  localparam logic [3:0] StateDir   = 4'd7;

  typedef enum logic [1:0] {StFight = 2'd0, StKo = 2'd1, StOver = 2'd2} round_e;

  round_e     state_q, state_d;
  logic [5:0] ko_cnt_q, ko_cnt_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
  logic       p1_lat_q, p1_lat_d, p2_lat_q, p2_lat_d;
  logic       p1_req_q, p1_req_d, p2_req_q, p2_req_d;
  logic       p1_blk_q, p1_blk_d, p2_blk_q, p2_blk_d;
  logic [4:0] p1_frm_q, p1_frm_d, p2_frm_q, p2_frm_d;

  logic [10:0] p1_x, p2_x;
  logic        p1_act, p2_act, p1_ovl, p2_ovl, p1_conn, p2_conn;
  logic        p1_def_blk, p2_def_blk;
  logic [7:0]  p1_dmg, p2_dmg;

  // Zero-extended to 11 bits so hitbox offsets near x = 1023 cannot wrap into a false overlap.
  assign p1_x   = {1'b0, bus.p1_pos_x};
  assign p2_x   = {1'b0, bus.p2_pos_x};
  assign p1_act = (bus.p1_state == StateBasic) || (bus.p1_state == StateDir);
  assign p2_act = (bus.p2_state == StateBasic) || (bus.p2_state == StateDir);
  // P1 hitbox [x+45, x+58) against P2 hurtbox [x+20, x+44); P2 hitbox is mirrored to [x+6, x+19).
  assign p1_ovl = (p1_x + 11'd45 < p2_x + 11'd44) && (p2_x + 11'd20 < p1_x + 11'd58);
  assign p2_ovl = (p2_x + 11'd6 < p1_x + 11'd44) && (p1_x + 11'd20 < p2_x + 11'd19);

  assign p1_conn = bus.frame_en && (state_q == StFight) && p1_act && p1_ovl && !p1_lat_q;
  assign p2_conn = bus.frame_en && (state_q == StFight) && p2_act && p2_ovl && !p2_lat_q;

  // Defender blocks by holding backward on the evaluated frame.
  assign p1_def_blk = (bus.p1_state == StateBwd);
  assign p2_def_blk = (bus.p2_state == StateBwd);
  // Damage taken by each player depends on the opponent's attack type.
  assign p1_dmg = (bus.p2_state == StateDir) ? DirDmg : BasicDmg;
  assign p2_dmg = (bus.p1_state == StateDir) ? DirDmg : BasicDmg;

  always_comb begin
    state_d  = state_q;
    ko_cnt_d = ko_cnt_q;
    winner_d = winner_q;
    p1_hp_d  = p1_hp_q;
    p2_hp_d  = p2_hp_q;
    p1_lat_d = p1_lat_q;
    p2_lat_d = p2_lat_q;
    p1_req_d = 1'b0;
    p2_req_d = 1'b0;
    p1_blk_d = p1_blk_q;
    p2_blk_d = p2_blk_q;
    p1_frm_d = p1_frm_q;
    p2_frm_d = p2_frm_q;

    // Latch re-arms only once the attacker has left its active state: one connect per attack.
    if (bus.frame_en && (state_q != StOver)) begin
      if (!p1_act) p1_lat_d = 1'b0;
      else if (p1_conn) p1_lat_d = 1'b1;
      if (!p2_act) p2_lat_d = 1'b0;
      else if (p2_conn) p2_lat_d = 1'b1;
    end

    // P2's attack lands on P1.
    if (p2_conn) begin
      p1_req_d = 1'b1;
      p1_blk_d = p1_def_blk;
      if (bus.p2_state == StateDir) p1_frm_d = p1_def_blk ? DirBlkF : DirHitF;
      else                          p1_frm_d = p1_def_blk ? BasicBlkF : BasicHitF;
      if (!p1_def_blk) p1_hp_d = (p1_hp_q > p1_dmg) ? p1_hp_q - p1_dmg : 8'd0;
    end

    // P1's attack lands on P2.
    if (p1_conn) begin
      p2_req_d = 1'b1;
      p2_blk_d = p2_def_blk;
      if (bus.p1_state == StateDir) p2_frm_d = p2_def_blk ? DirBlkF : DirHitF;
      else                          p2_frm_d = p2_def_blk ? BasicBlkF : BasicHitF;
      if (!p2_def_blk) p2_hp_d = (p2_hp_q > p2_dmg) ? p2_hp_q - p2_dmg : 8'd0;
    end

    case (state_q)
      StFight: begin
        if ((p1_hp_d == 8'd0) || (p2_hp_d == 8'd0)) begin
          state_d  = StKo;
          ko_cnt_d = 6'd0;
          if ((p1_hp_d == 8'd0) && (p2_hp_d == 8'd0)) winner_d = 2'd3;
          else if (p2_hp_d == 8'd0)                    winner_d = 2'd1;
          else                                         winner_d = 2'd2;
        end
      end
      StKo: begin
        if (bus.frame_en) begin
          if (ko_cnt_q == KoHold - 6'd1) state_d = StOver;
          else                           ko_cnt_d = ko_cnt_q + 6'd1;
        end
      end
      StOver: ;
      default: state_d = StFight;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFight;
      ko_cnt_q <= 6'd0;
      winner_q <= 2'd0;
      p1_hp_q  <= HpMax;
      p2_hp_q  <= HpMax;
      p1_lat_q <= 1'b0;
      p2_lat_q <= 1'b0;
      p1_req_q <= 1'b0;
      p2_req_q <= 1'b0;
      p1_blk_q <= 1'b0;
      p2_blk_q <= 1'b0;
      p1_frm_q <= 5'd0;
      p2_frm_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      ko_cnt_q <= ko_cnt_d;
      winner_q <= winner_d;
      p1_hp_q  <= p1_hp_d;
      p2_hp_q  <= p2_hp_d;
      p1_lat_q <= p1_lat_d;
      p2_lat_q <= p2_lat_d;
      p1_req_q <= p1_req_d;
      p2_req_q <= p2_req_d;
      p1_blk_q <= p1_blk_d;
      p2_blk_q <= p2_blk_d;
      p1_frm_q <= p1_frm_d;
      p2_frm_q <= p2_frm_d;
    end
  end

  assign bus.p1_stun_req = p1_req_q;
  assign bus.p1_stun_blk = p1_blk_q;
  assign bus.p1_stun_frm = p1_frm_q;
  assign bus.p2_stun_req = p2_req_q;
  assign bus.p2_stun_blk = p2_blk_q;
  assign bus.p2_stun_frm = p2_frm_q;
  assign bus.p1_health   = p1_hp_q;
  assign bus.p2_health   = p2_hp_q;
  assign bus.round_state = state_q;
  assign bus.winner      = winner_q;

endmodule
